hilo_div_seq: RTL and testbench

Sequencer that sits directly upstream of the iterative divider and owns the architectural HI/LO registers. It accepts a divide request from the main control unit, latches the operands, issues the one-cycle `DivCtrl` pulse to the divider, waits for `div_end` or `div_zero`, and writes the quotient to LO and the remainder to HI. It provides the busy/stall signal and the divide-by-zero exception pulse to the control unit, and it services MTHI/MTLO writes.

---
 rtl/hilo_div_seq.sv | 207 ++++++++++++++++++++
 tb/tb_hilo_div_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_seq.sv
// hilo_div_seq
//
// Sequencer between the main control unit and the iterative divider. It owns
// the architectural HI/LO registers. A divide request is latched, the divider
// gets a one-cycle start strobe, and the sequencer waits for completion or
// divide-by-zero. The quotient goes to LO and the remainder goes to HI.
// MTHI/MTLO writes are serviced while idle.
//
// Optional feature: define HILO_TIMEOUT_EN to build a WAIT watchdog that gives
// up after TIMEOUT cycles. Without it, `timeout` is tied low and WAIT waits
// forever.
//
// Parameters
//   DATA_W   operand / register width (32 for the architectural registers)
//   TIMEOUT  watchdog limit in WAIT cycles (1..255, HILO_TIMEOUT_EN only)
//
// Ports
//   clk                in   system clock, rising edge
//   reset              in   asynchronous active-low reset
//   start              in   divide request, sampled only in IDLE
//   op_a, op_b         in   dividend / divisor, latched with start
//   hi_we, lo_we       in   MTHI / MTLO write enables (IDLE only)
//   wdata              in   MTHI / MTLO data
//   div_high, div_low  in   divider remainder / quotient
//   div_end, div_zero  in   divider completion / divide-by-zero flags
//   div_ctrl           out  one-cycle start strobe to the divider
//   div_a, div_b       out  registered operands to the divider
//   hi, lo             out  architectural HI / LO
//   busy               out  high whenever not IDLE
//   done               out  one-cycle pulse, HI/LO updated
//   exc_div0           out  one-cycle pulse, divide-by-zero
//   timeout            out  one-cycle pulse, watchdog expired
module hilo_div_seq #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] op_a,
  input  logic signed [DATA_W-1:0] op_b,
  input  logic                     hi_we,
  input  logic                     lo_we,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic signed [DATA_W-1:0] div_high,
  input  logic signed [DATA_W-1:0] div_low,
  input  logic                     div_end,
  input  logic                     div_zero,
  output logic                     div_ctrl,
  output logic signed [DATA_W-1:0] div_a,
  output logic signed [DATA_W-1:0] div_b,
  output logic signed [DATA_W-1:0] hi,
  output logic signed [DATA_W-1:0] lo,
  output logic                     busy,
  output logic                     done,
  output logic                     exc_div0,
  output logic                     timeout
);

  // The watchdog counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("hilo_div_seq: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic ld_ops;    // accept a divide: capture operands
  logic ld_res;    // divider finished: capture quotient / remainder
  logic wr_hi;     // MTHI
  logic wr_lo;     // MTLO
  logic set_div0;  // divide-by-zero seen in WAIT

`ifdef HILO_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       expired;
  logic       set_tmo;

  // Cleared during ISSUE, so it is zero on entry to WAIT. It then counts WAIT
  // cycles. Expiry fires on the TIMEOUT-th WAIT edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign expired = (state == WAIT) && (wait_cnt == 8'(TIMEOUT - 1));
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and load controls
  always_comb begin
    state_nxt = state;
    ld_ops    = 1'b0;
    ld_res    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    set_div0  = 1'b0;
`ifdef HILO_TIMEOUT_EN
    set_tmo   = 1'b0;
`endif
    case (state)
      IDLE: begin
        // A write on the same edge as start still lands. The divide result
        // overwrites it later.
        wr_hi = hi_we;
        wr_lo = lo_we;
        if (start) begin
          ld_ops    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        // div_zero wins over div_end. Both win over an expiry on the same edge.
        if (div_zero) begin
          set_div0  = 1'b1;
          state_nxt = IDLE;
        end else if (div_end) begin
          ld_res    = 1'b1;
          state_nxt = DONE;
        end
`ifdef HILO_TIMEOUT_EN
        else if (expired) begin
          set_tmo   = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand and architectural registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_a <= '0;
      div_b <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (ld_ops) begin
        div_a <= op_a;
        div_b <= op_b;
      end
      if (ld_res) begin
        hi <= div_high;
        lo <= div_low;
      end else begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end
    end
  end

  // Exception pulses are registered. They are high for the IDLE cycle that
  // follows the abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exc_div0 <= 1'b0;
    end else begin
      exc_div0 <= set_div0;
    end
  end

`ifdef HILO_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout <= 1'b0;
    end else begin
      timeout <= set_tmo;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign div_ctrl = (state == ISSUE);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_hilo_div_seq.sv
module tb_hilo_div_seq;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] div_high;
  logic [31:0] div_low;
  logic        div_end;
  logic        div_zero;
  logic        div_ctrl;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        exc_div0;
  logic        timeout;

  hilo_div_seq #(.DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .div_high (div_high),
    .div_low  (div_low),
    .div_end  (div_end),
    .div_zero (div_zero),
    .div_ctrl (div_ctrl),
    .div_a    (div_a),
    .div_b    (div_b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .exc_div0 (exc_div0),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Divider stand-in. It samples the strobe on the E1 edge and clears stale
  // flags just after it. It flags divide-by-zero right away. Otherwise it
  // presents the result after 32 more edges (E33). With hang set, it never
  // finishes.
  logic        hang = 1'b0;
  logic [31:0] dv_a, dv_b;
  initial begin
    div_end = 1'b0; div_zero = 1'b0; div_high = '0; div_low = '0;
    forever begin
      @(negedge clk);
      if (div_ctrl === 1'b1) begin
        dv_a = div_a;
        dv_b = div_b;
        @(posedge clk);
        #1;
        div_end  = 1'b0;
        div_zero = 1'b0;
        if (dv_b == 32'd0) begin
          div_zero = 1'b1;
        end else if (!hang) begin
          repeat (32) @(posedge clk);
          #1;
          div_low  = $signed(dv_a) / $signed(dv_b);
          div_high = $signed(dv_a) % $signed(dv_b);
          div_end  = 1'b1;
        end
      end
    end
  end

  // Reference model. m_n counts edges since the start was accepted (0 = idle).
  // Each operation kind has a fixed busy length: 35 for a normal divide, 2 for
  // divide-by-zero, and TMO+1 for a watchdog abort.
  int          m_n = 0;
  int          m_len = 0;
  int          m_kind = 0;   // 0 normal, 1 div0, 2 timeout
  logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0, m_rhi = '0, m_rlo = '0;
  logic        m_exc = 1'b0, m_tmo = 1'b0;
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_n = 0; m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_exc = 1'b0; m_tmo = 1'b0;
    end else begin
      m_exc = 1'b0;
      m_tmo = 1'b0;
      if (m_n == 0) begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
        if (start) begin
          m_a = op_a; m_b = op_b; m_n = 1;
          if (op_b == 32'd0) begin
            m_kind = 1; m_len = 2;
          end else if (hang) begin
            m_kind = 2; m_len = TMO + 1;
          end else begin
            m_kind = 0; m_len = 35;
            m_rlo = $signed(op_a) / $signed(op_b);
            m_rhi = $signed(op_a) % $signed(op_b);
          end
        end
      end else begin
        m_n++;
        if (m_kind == 0 && m_n == 35) begin
          m_hi = m_rhi;
          m_lo = m_rlo;
        end
        if (m_n > m_len) begin
          m_n = 0;
          if (m_kind == 1) m_exc = 1'b1;
          if (m_kind == 2) m_tmo = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus event counters.
  int bc = 0, cc = 0, dc = 0, ec = 0, tc = 0;
  initial forever begin
    @(negedge clk);
    chk("busy",     {31'd0, busy},     {31'd0, (m_n >= 1 && m_n <= m_len)});
    chk("div_ctrl", {31'd0, div_ctrl}, {31'd0, (m_n == 1)});
    chk("done",     {31'd0, done},     {31'd0, (m_kind == 0 && m_n == 35)});
    chk("exc_div0", {31'd0, exc_div0}, {31'd0, m_exc});
    chk("timeout",  {31'd0, timeout},  {31'd0, m_tmo});
    chk("hi",       hi,    m_hi);
    chk("lo",       lo,    m_lo);
    chk("div_a",    div_a, m_a);
    chk("div_b",    div_b, m_b);
    if (busy)     bc++;
    if (div_ctrl) cc++;
    if (done)     dc++;
    if (exc_div0) ec++;
    if (timeout)  tc++;
  end

  task automatic clr_counts();
    bc = 0; cc = 0; dc = 0; ec = 0; tc = 0;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: busy still 1 after 100 cycles, expected 0", name);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_ctrl", {31'd0, div_ctrl}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 100 / 7
    clr_counts();
    launch(32'd100, 32'd7);
    wait_idle("div_100_7");
    chk("t1_lo", lo, 32'd14);
    chk("t1_hi", hi, 32'd2);
    chk("t1_busy_cycles", bc, 32'd35);
    chk("t1_ctrl_cycles", cc, 32'd1);
    chk("t1_done_cycles", dc, 32'd1);

    // -100 / 7, bit-exact passthrough
    launch(32'hFFFF_FF9C, 32'd7);
    wait_idle("div_m100_7");
    chk("t2_lo", lo, 32'hFFFF_FFF2);
    chk("t2_hi", hi, 32'hFFFF_FFFE);

    // MTLO then divide by zero
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    lo_we = 1'b0;
    chk("t3_mtlo", lo, 32'h1234);
    clr_counts();
    launch(32'd77, 32'd0);
    wait_idle("div_zero");
    chk("t3_lo", lo, 32'h1234);
    chk("t3_hi", hi, 32'hFFFF_FFFE);
    chk("t3_exc_cycles", ec, 32'd1);
    chk("t3_done_cycles", dc, 32'd0);
    chk("t3_busy_cycles", bc, 32'd2);

    // start and MTHI held during the divide are ignored
    clr_counts();
    @(negedge clk);
    op_a = 32'd50; op_b = 32'd7; start = 1'b1;
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hAAAA;
    repeat (25) @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    wait_idle("div_busy_ignore");
    chk("t4_hi", hi, 32'd1);
    chk("t4_lo", lo, 32'd7);
    chk("t4_ctrl_cycles", cc, 32'd1);
    chk("t4_done_cycles", dc, 32'd1);

    // Asynchronous reset mid-divide, then a stale div_end in IDLE
    clr_counts();
    launch(32'd100, 32'd7);
    repeat (19) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_ctrl", {31'd0, div_ctrl}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_hi", hi, 32'd0);
    chk("t5_lo", lo, 32'd0);
    chk("t5_div_a", div_a, 32'd0);
    chk("t5_div_b", div_b, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_no_done", dc, 32'd0);

    // 9 / 3, with MTHI on the accepting edge
    @(negedge clk);
    op_a = 32'd9; op_b = 32'd3; start = 1'b1; hi_we = 1'b1; wdata = 32'h5555;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk("t5_same_edge_hi", hi, 32'h5555);
    wait_idle("div_9_3");
    chk("t5_lo", lo, 32'd3);
    chk("t5_hi_final", hi, 32'd0);

`ifdef HILO_TIMEOUT_EN
    // Watchdog: the divider never finishes
    hang = 1'b1;
    clr_counts();
    launch(32'd5, 32'd1);
    wait_idle("div_timeout");
    chk("t6_tmo_cycles", tc, 32'd1);
    chk("t6_busy_cycles", bc, TMO + 1);
    chk("t6_done_cycles", dc, 32'd0);
    chk("t6_hi", hi, 32'd0);
    chk("t6_lo", lo, 32'd3);
    hang = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
